// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages of the MIPS core.
// Holds the skid-stage state encoding, default widths and per-stage payload widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int CNT_W_DEF  = 32;

   // Payload widths of each core stage boundary, so every stage instantiates from one place
   localparam int IFID_W  = 64;
   localparam int IDEX_W  = 148;
   localparam int EXMEM_W = 107;
   localparam int MEMWB_W = 71;

   // Encoding is {skid_v, main_v}; 2'b10 is unreachable
   typedef enum logic [1:0] {
      PS_EMPTY = 2'b00,
      PS_ONE   = 2'b01,
      PS_TWO   = 2'b11
   } pipeState_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the skid stage
// performance counters (built only with PIPE_STAGE_PERF_EN).
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Clear wins over increment; once all-ones the count sticks until cleared
   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer and a registered in_ready.
// Optional stall/bubble performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int CNT_W  = CNT_W_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   pipeState_t        r_state;
   pipeState_t        w_stateNext;
   logic [DATA_W-1:0] r_mainQ;
   logic [DATA_W-1:0] r_skidQ;
   logic [DATA_W-1:0] w_mainQNext;
   logic [DATA_W-1:0] w_skidQNext;
   logic              w_mainV;
   logic              w_skidV;
   logic              w_xferIn;
   logic              w_xferOut;

   assign w_mainV   = r_state[0];
   assign w_skidV   = r_state[1];
   assign w_xferIn  = in_valid & ~w_skidV;
   assign w_xferOut = w_mainV & out_ready;

   // State and payload registers; reset and flush both leave an all-zero empty stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= PS_EMPTY;
         r_mainQ <= '0;
         r_skidQ <= '0;
      end else begin
         r_state <= w_stateNext;
         r_mainQ <= w_mainQNext;
         r_skidQ <= w_skidQNext;
      end
   end

   // Next state: skid always drains into main before new input can reach main
   always_comb begin
      w_stateNext = r_state;
      w_mainQNext = r_mainQ;
      w_skidQNext = r_skidQ;
      case (r_state)
         PS_EMPTY: begin
            if (w_xferIn) begin
               w_stateNext = PS_ONE;
               w_mainQNext = in_data;
            end
         end
         PS_ONE: begin
            if (w_xferIn && w_xferOut) begin
               w_mainQNext = in_data;
            end else if (w_xferIn) begin
               w_stateNext = PS_TWO;
               w_skidQNext = in_data;
            end else if (w_xferOut) begin
               w_stateNext = PS_EMPTY;
            end
         end
         PS_TWO: begin
            if (w_xferOut) begin
               w_stateNext = PS_ONE;
               w_mainQNext = r_skidQ;
            end
         end
         default: begin
            w_stateNext = PS_EMPTY;
         end
      endcase
      if (flush) begin
         w_stateNext = PS_EMPTY;
         w_mainQNext = '0;
         w_skidQNext = '0;
      end
   end

   assign in_ready  = ~w_skidV;
   assign out_valid = w_mainV;
   assign out_data  = w_mainV ? r_mainQ : '0;

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
      .clk     (clk),
      .i_clear (rst),
      .i_inc   (w_mainV & ~out_ready),
      .o_count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubbleCnt (
      .clk     (clk),
      .i_clear (rst),
      .i_inc   (~w_mainV),
      .o_count (bubble_cnt)
   );
`else
   // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios then random traffic,
// all compared against a queue-based reference model of a two-deep elastic buffer.
module tb_pipe_stage_skid;

   localparam int DW  = 8;
   localparam int CW  = 3;
   localparam int CAP = 2;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mq[$];
   int            mStall  = 0;
   int            mBubble = 0;

   always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
   pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );
`else
   pipe_stage_skid #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );
`endif

   // Compare DUT outputs against the model's view of the buffered words
   task automatic checkOutput(input string tag);
      logic          expReady;
      logic          expValid;
      logic [DW-1:0] expData;
      expReady = (mq.size() < CAP);
      expValid = (mq.size() > 0);
      expData  = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      assert (in_ready === expReady) else begin
         errors++;
         $error("[TB] FAIL %s in_ready observed %b expected %b", tag, in_ready, expReady);
      end
      checks++;
      assert (out_valid === expValid) else begin
         errors++;
         $error("[TB] FAIL %s out_valid observed %b expected %b", tag, out_valid, expValid);
      end
      checks++;
      assert (out_data === expData) else begin
         errors++;
         $error("[TB] FAIL %s out_data observed %h expected %h", tag, out_data, expData);
      end
`ifdef PIPE_STAGE_PERF_EN
      checks++;
      assert (int'(stall_cnt) === mStall) else begin
         errors++;
         $error("[TB] FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, mStall);
      end
      checks++;
      assert (int'(bubble_cnt) === mBubble) else begin
         errors++;
         $error("[TB] FAIL %s bubble_cnt observed %0d expected %0d", tag, bubble_cnt, mBubble);
      end
`endif
   endtask

   // Reference: a FIFO of capacity two; downstream pops before upstream pushes
   task automatic modelUpdate();
      bit xIn;
      bit xOut;
      xIn  = in_valid && (mq.size() < CAP);
      xOut = (mq.size() > 0) && out_ready;
      if (rst) begin
         mStall  = 0;
         mBubble = 0;
      end else begin
         if ((mq.size() > 0) && !out_ready && (mStall < SAT)) mStall++;
         if ((mq.size() == 0) && (mBubble < SAT)) mBubble++;
      end
      if (rst || flush) begin
         mq.delete();
      end else begin
         if (xOut) void'(mq.pop_front());
         if (xIn) mq.push_back(in_data);
      end
   endtask

   // One clock cycle: drive inputs, check mid-cycle, then advance model with the edge
   task automatic applyStimulus(input string tag, input bit v, input logic [DW-1:0] d,
                                input bit r, input bit f, input bit rs);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      rst       = rs;
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clk);
      modelUpdate();
      #1;

      applyStimulus("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus("reset_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Back-to-back streaming with downstream always ready
      for (int i = 1; i <= 16; i++) begin
         applyStimulus("stream", 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus("stream_tail", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Back-pressure: A3 must wait upstream until the skid has drained
      applyStimulus("bp_a1", 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      applyStimulus("bp_a2", 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
      applyStimulus("bp_a3_held", 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      applyStimulus("bp_a3_held2", 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      applyStimulus("bp_drain1", 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
      applyStimulus("bp_drain2", 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
      applyStimulus("bp_drain3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus("bp_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Flush while full, with a word offered in the same cycle
      applyStimulus("fl_fill1", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus("fl_fill2", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus("fl_pulse", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      applyStimulus("fl_after", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus("fl_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Reset asserted for one cycle in the middle of streaming
      for (int i = 0; i < 4; i++) begin
         applyStimulus("rs_stream", 1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
      end
      applyStimulus("rs_pulse", 1'b1, 8'h3F, 1'b1, 1'b0, 1'b1);
      applyStimulus("rs_after", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Ten stall cycles saturate a 3-bit stall counter; flush leaves counters alone
      applyStimulus("cnt_load", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus("cnt_stall", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus("cnt_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus("cnt_after_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("cnt_bubble", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         applyStimulus("random", 1'($urandom_range(0, 1)), 8'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                       ($urandom_range(0, 59) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
